// File: rtl/iob2axi_sched_pkg.sv
// Shared definitions for the iob2axi transfer scheduler: FSM state encoding
// and a constant-evaluable ceil(log2) helper used to size counters and indices.
package iob2axi_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_e;

    // Number of bits needed to hold values 0 .. value-1 (at least 1).
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 32'sd0;
        rem = value - 32'sd1;
        while (rem > 32'sd0) begin
            res = res + 32'sd1;
            rem = rem >>> 1;
        end
        if (res < 32'sd1) begin
            res = 32'sd1;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/iob2axi_rr_arb.sv
// NREQ-way round-robin arbiter. Picks the first active request at or after
// the pointer (wrapping); the pointer moves past the winner only when the
// grant strobe confirms that the grant was actually taken.
module iob2axi_rr_arb
    import iob2axi_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             gnt_stb,
    output logic             gnt_any,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    int               cand_s;

    // Search for the first active requester starting at the pointer.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand_s  = 32'sd0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = (int'(ptr_q) + k) % NREQ;
            if (!gnt_any && req[cand_s]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(cand_s);
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

    // Advance the pointer to one past the winner on a taken grant.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_stb) begin
            if (gnt_idx == IDX_W'(NREQ - 1)) begin
                ptr_d = {IDX_W{1'b0}};
            end else begin
                ptr_d = gnt_idx + IDX_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {IDX_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/iob2axi_sched.sv
// Shares one iob2axi engine between NREQ native requesters. Grants
// round-robin, programs the engine, routes the owner's native port to the
// engine, counts beats, then drains (write) or flushes (read) the engine until
// it has been quiet long enough that the next owner starts with clean FIFOs.
module iob2axi_sched
    import iob2axi_sched_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int DRAIN_CYC = 260
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_dir,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*LEN_W-1:0]      req_len,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            req_done,
    output logic [NREQ-1:0]            req_err,
    input  logic [NREQ-1:0]            r_s_valid,
    input  logic [NREQ*ADDR_W-1:0]     r_s_addr,
    input  logic [NREQ*DATA_W-1:0]     r_s_wdata,
    input  logic [NREQ*DATA_W/8-1:0]   r_s_wstrb,
    output logic [DATA_W-1:0]          r_s_rdata,
    output logic [NREQ-1:0]            r_s_ready,
    output logic                       e_run,
    output logic                       e_direction,
    output logic [ADDR_W-1:0]          e_addr,
    input  logic                       e_ready,
    input  logic                       e_error,
    output logic                       e_s_valid,
    output logic [ADDR_W-1:0]          e_s_addr,
    output logic [DATA_W-1:0]          e_s_wdata,
    output logic [DATA_W/8-1:0]        e_s_wstrb,
    input  logic [DATA_W-1:0]          e_s_rdata,
    input  logic                       e_s_ready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = clog2(NREQ);
    localparam int QW     = clog2(DRAIN_CYC + 1);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  g_q, g_d;
    logic              dir_q, dir_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [QW-1:0]     quiet_q, quiet_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic [NREQ-1:0]   req_done_q, req_done_d;
    logic [NREQ-1:0]   req_err_q, req_err_d;
    logic              e_run_q, e_run_d;
    logic              e_dir_q, e_dir_d;
    logic [ADDR_W-1:0] e_addr_q, e_addr_d;

    logic              gnt_any_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic              gnt_stb_s;

    logic              sel_valid_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [STRB_W-1:0] sel_wstrb_s;
    logic              beat_ok_s;
    logic              hs_s;
    logic              mismatch_s;
    logic [LEN_W-1:0]  beat_inc_s;
    logic [QW-1:0]     quiet_inc_s;

    iob2axi_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .gnt_stb (gnt_stb_s),
        .gnt_any (gnt_any_s),
        .gnt_idx (gnt_idx_s)
    );

    // Owner's native port slice and beat classification.
    always_comb begin
        sel_valid_s = r_s_valid[g_q];
        sel_addr_s  = r_s_addr[int'(g_q)*ADDR_W +: ADDR_W];
        sel_wdata_s = r_s_wdata[int'(g_q)*DATA_W +: DATA_W];
        sel_wstrb_s = r_s_wstrb[int'(g_q)*STRB_W +: STRB_W];
        if (dir_q) begin
            beat_ok_s = |sel_wstrb_s;
        end else begin
            beat_ok_s = ~|sel_wstrb_s;
        end
        hs_s        = (state_q == ST_XFER) && sel_valid_s && beat_ok_s && e_s_ready;
        mismatch_s  = (state_q == ST_XFER) && sel_valid_s && !beat_ok_s;
        beat_inc_s  = beat_q + LEN_W'(1);
        if (quiet_q == QW'(DRAIN_CYC)) begin
            quiet_inc_s = quiet_q;
        end else begin
            quiet_inc_s = quiet_q + QW'(1);
        end
    end

    // Combinational native path: owner -> engine in XFER, read pops in FLUSH.
    always_comb begin
        e_s_valid = 1'b0;
        e_s_addr  = {ADDR_W{1'b0}};
        e_s_wdata = {DATA_W{1'b0}};
        e_s_wstrb = {STRB_W{1'b0}};
        r_s_ready = {NREQ{1'b0}};
        r_s_rdata = {DATA_W{1'b0}};
        if (state_q == ST_XFER) begin
            e_s_valid      = sel_valid_s && beat_ok_s;
            e_s_addr       = sel_addr_s;
            e_s_wdata      = sel_wdata_s;
            e_s_wstrb      = sel_wstrb_s;
            r_s_ready[g_q] = e_s_ready && beat_ok_s;
            r_s_rdata      = e_s_rdata;
        end else if (state_q == ST_FLUSH) begin
            e_s_valid = 1'b1;
            e_s_addr  = sel_addr_s;
        end else begin
            e_s_valid = 1'b0;
        end
    end

    // Scheduler FSM next-state, counters and registered-output next values.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        dir_d       = dir_q;
        len_d       = len_q;
        err_d       = err_q;
        beat_d      = beat_q;
        quiet_d     = quiet_q;
        req_ready_d = {NREQ{1'b0}};
        req_done_d  = {NREQ{1'b0}};
        req_err_d   = {NREQ{1'b0}};
        e_run_d     = 1'b0;
        e_dir_d     = e_dir_q;
        e_addr_d    = e_addr_q;
        gnt_stb_s   = 1'b0;

        if ((state_q != ST_IDLE) && (e_error || mismatch_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                beat_d  = {LEN_W{1'b0}};
                quiet_d = {QW{1'b0}};
                if (gnt_any_s) begin
                    gnt_stb_s              = 1'b1;
                    g_d                    = gnt_idx_s;
                    dir_d                  = req_dir[gnt_idx_s];
                    len_d                  = req_len[int'(gnt_idx_s)*LEN_W +: LEN_W];
                    e_dir_d                = req_dir[gnt_idx_s];
                    e_addr_d               = req_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
                    req_ready_d[gnt_idx_s] = 1'b1;
                    state_d                = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (len_q == {LEN_W{1'b0}}) begin
                    state_d = ST_DONE;
                end else if (e_ready) begin
                    e_run_d = 1'b1;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_XFER: begin
                if (hs_s) begin
                    beat_d = beat_inc_s;
                    if (beat_inc_s == len_q) begin
                        quiet_d = {QW{1'b0}};
                        state_d = dir_q ? ST_DRAIN : ST_FLUSH;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_DRAIN: begin
                if (e_ready) begin
                    quiet_d = quiet_inc_s;
                    if (quiet_inc_s == QW'(DRAIN_CYC)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    quiet_d = {QW{1'b0}};
                end
            end
            ST_FLUSH: begin
                // Quiet only once the engine is idle and has nothing left to pop.
                if (e_ready && !e_s_ready) begin
                    quiet_d = quiet_inc_s;
                    if (quiet_inc_s == QW'(DRAIN_CYC)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else begin
                    quiet_d = {QW{1'b0}};
                end
            end
            ST_DONE: begin
                req_done_d[g_q] = 1'b1;
                req_err_d[g_q]  = err_q;
                err_d           = 1'b0;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            g_q         <= {IDX_W{1'b0}};
            dir_q       <= 1'b0;
            len_q       <= {LEN_W{1'b0}};
            err_q       <= 1'b0;
            beat_q      <= {LEN_W{1'b0}};
            quiet_q     <= {QW{1'b0}};
            req_ready_q <= {NREQ{1'b0}};
            req_done_q  <= {NREQ{1'b0}};
            req_err_q   <= {NREQ{1'b0}};
            e_run_q     <= 1'b0;
            e_dir_q     <= 1'b0;
            e_addr_q    <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            dir_q       <= dir_d;
            len_q       <= len_d;
            err_q       <= err_d;
            beat_q      <= beat_d;
            quiet_q     <= quiet_d;
            req_ready_q <= req_ready_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            e_run_q     <= e_run_d;
            e_dir_q     <= e_dir_d;
            e_addr_q    <= e_addr_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign req_done    = req_done_q;
    assign req_err     = req_err_q;
    assign e_run       = e_run_q;
    assign e_direction = e_dir_q;
    assign e_addr      = e_addr_q;

endmodule

// File: tb/tb_iob2axi_sched.sv
// Directed bench for iob2axi_sched with a small behavioural engine model:
// writes are logged, reads come from a 4-word prefetch FIFO filled on each
// read run, so a missing flush shows up as stale data on the next read.
module tb_iob2axi_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_dir;
    logic [63:0] req_addr;
    logic [31:0] req_len;
    logic [1:0]  req_ready, req_done, req_err;
    logic [1:0]  r_s_valid;
    logic [63:0] r_s_addr;
    logic [63:0] r_s_wdata;
    logic [7:0]  r_s_wstrb;
    logic [31:0] r_s_rdata;
    logic [1:0]  r_s_ready;
    logic        e_run, e_direction, e_ready, e_error;
    logic [31:0] e_addr;
    logic        e_s_valid;
    logic [31:0] e_s_addr, e_s_wdata, e_s_rdata;
    logic [3:0]  e_s_wstrb;
    logic        e_s_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    iob2axi_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dir(req_dir), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .r_s_valid(r_s_valid), .r_s_addr(r_s_addr), .r_s_wdata(r_s_wdata), .r_s_wstrb(r_s_wstrb),
        .r_s_rdata(r_s_rdata), .r_s_ready(r_s_ready),
        .e_run(e_run), .e_direction(e_direction), .e_addr(e_addr),
        .e_ready(e_ready), .e_error(e_error),
        .e_s_valid(e_s_valid), .e_s_addr(e_s_addr), .e_s_wdata(e_s_wdata), .e_s_wstrb(e_s_wstrb),
        .e_s_rdata(e_s_rdata), .e_s_ready(e_s_ready)
    );

    // ---------------- engine model ----------------
    int          busy;
    int          rf_head;
    int          rf_cnt;
    logic [31:0] rf [0:15];
    logic        err_inject;
    logic        eng_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    assign e_ready   = (busy == 0);
    assign e_error   = err_inject;
    assign e_s_ready = e_s_valid && ((e_s_wstrb != 4'h0) || (rf_cnt > 0));
    assign e_s_rdata = rf[rf_head];
    assign eng_pop   = e_s_valid && e_s_ready && (e_s_wstrb == 4'h0);

    // Engine: busy after run/beat, read prefetch FIFO.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 0;
            rf_head <= 0;
            rf_cnt  <= 0;
        end else begin
            if (e_run || (e_s_valid && e_s_ready)) busy <= 5;
            else if (busy > 0) busy <= busy - 1;
            if (e_run && !e_direction) begin
                for (int k = 0; k < 4; k++)
                    rf[(rf_head + rf_cnt + k) % 16] <= mem_word(e_addr + 32'(4 * k));
            end
            rf_head <= (rf_head + (eng_pop ? 1 : 0)) % 16;
            rf_cnt  <= rf_cnt - (eng_pop ? 1 : 0) + ((e_run && !e_direction) ? 4 : 0);
        end
    end

    // ---------------- monitors ----------------
    int          run_cnt = 0;
    logic [31:0] run_addr = 32'h0;
    logic        run_dir = 1'b0;
    int          esv_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] wlog [$];
    int          gnt_log [$];

    // Observe engine programming, native traffic, grants and completions.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (e_run) begin
            run_cnt  <= run_cnt + 1;
            run_addr <= e_addr;
            run_dir  <= e_direction;
        end
        if (e_s_valid) esv_cnt <= esv_cnt + 1;
        if (e_s_valid && e_s_ready && (e_s_wstrb != 4'h0)) wlog.push_back(e_s_wdata);
        for (int p = 0; p < 2; p++) if (req_ready[p]) gnt_log.push_back(p);
        if (|req_done) done_cnt <= done_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int p, output bit ok, output int c);
        ok = 1'b0; c = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin ok = 1'b1; c = cyc; break; end
        end
    endtask

    task automatic wait_done(input int p, output bit ok, output logic er, output int c);
        ok = 1'b0; er = 1'bx; c = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_done[p]) begin ok = 1'b1; er = req_err[p]; c = cyc; break; end
        end
    endtask

    task automatic request(input int p, input logic dir, input logic [31:0] addr,
                           input logic [15:0] len, output bit ok, output int c);
        req_valid[p] = 1'b1;
        req_dir[p] = dir;
        req_addr[p*32 +: 32] = addr;
        req_len[p*16 +: 16] = len;
        wait_ready(p, ok, c);
        req_valid[p] = 1'b0;
    endtask

    task automatic beat(input int p, input logic [3:0] strb, input logic [31:0] wd,
                        output logic [31:0] rd, output bit ok, output int hc);
        r_s_valid[p] = 1'b1;
        r_s_wstrb[p*4 +: 4] = strb;
        r_s_wdata[p*32 +: 32] = wd;
        r_s_addr[p*32 +: 32] = 32'h0;
        ok = 1'b0; rd = 32'h0; hc = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (r_s_ready[p]) begin ok = 1'b1; rd = r_s_rdata; hc = cyc; end
            @(negedge clk);
            if (ok) break;
        end
        r_s_valid[p] = 1'b0;
        r_s_wstrb[p*4 +: 4] = 4'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit          ok;
        logic        er;
        logic [31:0] rd;
        int          hc, dc, rc, d0, r1, runs0, esv0, done0;

        rst = 1'b1;
        req_valid = 2'b00; req_dir = 2'b00; req_addr = 64'h0; req_len = 32'h0;
        r_s_valid = 2'b00; r_s_addr = 64'h0; r_s_wdata = 64'h0; r_s_wstrb = 8'h0;
        err_inject = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {30'h0, req_ready}, 32'h0);
        chk("rst_req_done", {30'h0, req_done}, 32'h0);
        chk("rst_e_run", {31'h0, e_run}, 32'h0);
        chk("rst_e_dir", {31'h0, e_direction}, 32'h0);
        chk("rst_e_addr", e_addr, 32'h0);
        chk("rst_e_s_valid", {31'h0, e_s_valid}, 32'h0);
        chk("rst_r_s_ready", {30'h0, r_s_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // T1: write 4 beats at 0x1000
        runs0 = run_cnt;
        wlog.delete();
        request(0, 1'b1, 32'h1000, 16'd4, ok, rc);
        chk("t1_grant", {31'h0, ok}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            beat(0, 4'hF, 32'hA0 + 32'(i), rd, ok, hc);
            chk("t1_beat_hs", {31'h0, ok}, 32'h1);
        end
        wait_done(0, ok, er, dc);
        chk("t1_done", {31'h0, ok}, 32'h1);
        chk("t1_err", {31'h0, er}, 32'h0);
        chk("t1_drain_cycles", 32'(dc - hc), 32'd267);
        chk("t1_run_cnt", 32'(run_cnt - runs0), 32'd1);
        chk("t1_run_addr", run_addr, 32'h1000);
        chk("t1_run_dir", {31'h0, run_dir}, 32'h1);
        chk("t1_wlog_size", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_wdata", wlog[i], 32'hA0 + 32'(i));

        // T2 + T4: simultaneous zero-length requests from reset, round-robin
        do_reset();
        gnt_log.delete();
        runs0 = run_cnt;
        esv0 = esv_cnt;
        req_len = 32'h0;
        req_dir = 2'b11;
        req_valid = 2'b11;
        wait_ready(0, ok, rc);
        chk("t2_first_grant0", {31'h0, ok}, 32'h1);
        req_valid[0] = 1'b0;
        wait_done(0, ok, er, d0);
        chk("t4_done", {31'h0, ok}, 32'h1);
        chk("t4_ready_to_done", 32'(d0 - rc), 32'd2);
        req_valid[0] = 1'b1;
        wait_ready(1, ok, r1);
        chk("t2_grant1", {31'h0, ok}, 32'h1);
        chk("t2_grant1_lat", 32'(r1 - d0), 32'd1);
        req_valid[1] = 1'b0;
        wait_done(1, ok, er, dc);
        chk("t2_done1", {31'h0, ok}, 32'h1);
        wait_ready(0, ok, rc);
        chk("t2_regrant0", {31'h0, ok}, 32'h1);
        req_valid[0] = 1'b0;
        wait_done(0, ok, er, dc);
        chk("t2_gnt_log_size", 32'(gnt_log.size()), 32'd3);
        chk("t2_gnt_order0", 32'(gnt_log[0]), 32'd0);
        chk("t2_gnt_order1", 32'(gnt_log[1]), 32'd1);
        chk("t2_gnt_order2", 32'(gnt_log[2]), 32'd0);
        chk("t4_no_run", 32'(run_cnt - runs0), 32'd0);
        chk("t4_no_traffic", 32'(esv_cnt - esv0), 32'd0);

        // T3: read 3 words at 0x2000, then 1 word at 0x3000 after flush
        request(1, 1'b0, 32'h2000, 16'd3, ok, rc);
        chk("t3_grant", {31'h0, ok}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            beat(1, 4'h0, 32'h0, rd, ok, hc);
            chk("t3_rdata", rd, mem_word(32'h2000 + 32'(4 * i)));
        end
        wait_done(1, ok, er, dc);
        chk("t3_done", {31'h0, ok}, 32'h1);
        chk("t3_err", {31'h0, er}, 32'h0);
        request(1, 1'b0, 32'h3000, 16'd1, ok, rc);
        beat(1, 4'h0, 32'h0, rd, ok, hc);
        chk("t3_fresh_rdata", rd, 32'h3000C0DE);
        wait_done(1, ok, er, dc);
        chk("t3_done2", {31'h0, ok}, 32'h1);

        // T5: engine error mid-write, then a clean transfer
        request(0, 1'b1, 32'h4000, 16'd3, ok, rc);
        beat(0, 4'hF, 32'hB0, rd, ok, hc);
        err_inject = 1'b1;
        @(negedge clk);
        err_inject = 1'b0;
        beat(0, 4'hF, 32'hB1, rd, ok, hc);
        beat(0, 4'hF, 32'hB2, rd, ok, hc);
        wait_done(0, ok, er, dc);
        chk("t5_done", {31'h0, ok}, 32'h1);
        chk("t5_err_set", {31'h0, er}, 32'h1);
        request(0, 1'b1, 32'h4100, 16'd1, ok, rc);
        beat(0, 4'hF, 32'hB3, rd, ok, hc);
        wait_done(0, ok, er, dc);
        chk("t5_err_clear", {31'h0, er}, 32'h0);
        chk("t5_run_addr", run_addr, 32'h4100);

        // Beat-type mismatch on a read: not forwarded, flags error
        request(1, 1'b0, 32'h5000, 16'd1, ok, rc);
        @(negedge clk);
        r_s_valid[1] = 1'b1;
        r_s_wstrb[7:4] = 4'hF;
        #1;
        chk("mm_no_ready", {31'h0, r_s_ready[1]}, 32'h0);
        chk("mm_no_fwd", {31'h0, e_s_valid}, 32'h0);
        @(negedge clk);
        r_s_valid[1] = 1'b0;
        r_s_wstrb[7:4] = 4'h0;
        beat(1, 4'h0, 32'h0, rd, ok, hc);
        chk("mm_rdata", rd, 32'h5000C0DE);
        wait_done(1, ok, er, dc);
        chk("mm_err", {31'h0, er}, 32'h1);

        // T6: reset after 2 of 8 beats, then a fresh transfer
        request(0, 1'b1, 32'h6000, 16'd8, ok, rc);
        beat(0, 4'hF, 32'hC0, rd, ok, hc);
        beat(0, 4'hF, 32'hC1, rd, ok, hc);
        done0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("t6_e_s_valid", {31'h0, e_s_valid}, 32'h0);
        chk("t6_r_s_ready", {30'h0, r_s_ready}, 32'h0);
        chk("t6_e_addr", e_addr, 32'h0);
        chk("t6_e_dir", {31'h0, e_direction}, 32'h0);
        chk("t6_e_run", {31'h0, e_run}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt - done0), 32'd0);
        request(0, 1'b1, 32'h7000, 16'd2, ok, rc);
        chk("t6_fresh_grant", {31'h0, ok}, 32'h1);
        beat(0, 4'hF, 32'hD0, rd, ok, hc);
        beat(0, 4'hF, 32'hD1, rd, ok, hc);
        wait_done(0, ok, er, dc);
        chk("t6_fresh_done", {31'h0, ok}, 32'h1);
        chk("t6_fresh_err", {31'h0, er}, 32'h0);
        chk("t6_fresh_addr", run_addr, 32'h7000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
